// File: rtl/cpu_control_sequencer.sv
// Microcode sequencer for the 8-bit CPU. It holds the micro-step counter
// and the halt latch, and decodes (step, opcode, flags) into the 16-bit
// control word that drives every bus driver and register load.
module cpu_control_sequencer #(
  parameter int NUM_STEPS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_en,
  input  logic [3:0]  opcode,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
    OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
  } op_t;

  // Control word bit masks
  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  step_t       state_q, state_nx;
  logic        halted_q, halted_nx;
  step_t       last_step;
  logic [15:0] exec_word;

  // Step counter and halt latch; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= T0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_nx;
      halted_q <= halted_nx;
    end
  end

  // Per-opcode last step and execute-phase control word (T2..T4)
  always_comb begin
    last_step = T1;
    exec_word = '0;
    case (opcode)
      OP_LDA: begin
        last_step = T3;
        if (state_q == T2)      exec_word = C_IO | C_MI;
        else if (state_q == T3) exec_word = C_RO | C_AI;
      end
      OP_ADD, OP_SUB: begin
        last_step = T4;
        if (state_q == T2)      exec_word = C_IO | C_MI;
        else if (state_q == T3) exec_word = C_RO | C_BI;
        else if (state_q == T4) exec_word = C_EO | C_AI | C_FI | ((opcode == OP_SUB) ? C_SU : '0);
      end
      OP_STA: begin
        last_step = T3;
        if (state_q == T2)      exec_word = C_IO | C_MI;
        else if (state_q == T3) exec_word = C_AO | C_RI;
      end
      OP_LDI: begin
        last_step = T2;
        if (state_q == T2) exec_word = C_IO | C_AI;
      end
      OP_JMP: begin
        last_step = T2;
        if (state_q == T2) exec_word = C_IO | C_J;
      end
      OP_JC: begin
        last_step = T2;
        if (state_q == T2 && flag_c) exec_word = C_IO | C_J;
      end
      OP_JZ: begin
        last_step = T2;
        if (state_q == T2 && flag_z) exec_word = C_IO | C_J;
      end
      OP_OUT: begin
        last_step = T2;
        if (state_q == T2) exec_word = C_AO | C_OI;
      end
      OP_HLT: begin
        last_step = T2;
        if (state_q == T2) exec_word = C_HLT;
      end
      default: last_step = T1;
    endcase
  end

  // Next step / halt decision; out-of-range steps fall back to T0
  always_comb begin
    state_nx  = state_q;
    halted_nx = halted_q;
    if (step_en && !halted_q) begin
      if (state_q == T2 && opcode == OP_HLT) begin
        halted_nx = 1'b1;
        state_nx  = T0;
      end else if (state_q == last_step || state_q >= 3'(NUM_STEPS - 1)) begin
        state_nx = T0;
      end else begin
        state_nx = step_t'(state_q + 3'd1);
      end
    end
  end

  // Control word output: halt overrides, fetch is opcode-independent
  always_comb begin
    ctrl = exec_word;
    if (halted_q)           ctrl = C_HLT;
    else if (state_q == T0) ctrl = C_CO | C_MI;
    else if (state_q == T1) ctrl = C_RO | C_II | C_CE;
  end

  assign step   = state_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer: walks representative opcodes
// through fetch/execute, exercises stall, flag sampling, halt and reset.
module tb_cpu_control_sequencer;

  logic        clk;
  logic        rst;
  logic        step_en;
  logic [3:0]  opcode;
  logic        flag_c;
  logic        flag_z;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  cpu_control_sequencer #(.NUM_STEPS(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .step_en (step_en),
    .opcode  (opcode),
    .flag_c  (flag_c),
    .flag_z  (flag_z),
    .ctrl    (ctrl),
    .step    (step),
    .halted  (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Check all three outputs at the current instant
  task automatic check_all(input string tag, input logic [15:0] ec, input logic [2:0] es,
                           input logic eh);
    check({tag, ".ctrl"}, ctrl, ec);
    check({tag, ".step"}, {13'd0, step}, {13'd0, es});
    check({tag, ".halted"}, {15'd0, halted}, {15'd0, eh});
  endtask

  // Let one rising edge pass, then sample on the falling edge
  task automatic tick_check(input string tag, input logic [15:0] ec, input logic [2:0] es,
                            input logic eh);
    @(negedge clk);
    check_all(tag, ec, es, eh);
  endtask

  initial begin
    rst = 1'b1; step_en = 1'b0; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all("reset", 16'h4004, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick_check("idle", 16'h4004, 3'd0, 1'b0);

    // LDI
    opcode = 4'h5; step_en = 1'b1;
    check_all("ldi_t0", 16'h4004, 3'd0, 1'b0);
    tick_check("ldi_t1", 16'h1408, 3'd1, 1'b0);
    tick_check("ldi_t2", 16'h0A00, 3'd2, 1'b0);
    tick_check("ldi_wrap", 16'h4004, 3'd0, 1'b0);

    // SUB
    opcode = 4'h3;
    tick_check("sub_t1", 16'h1408, 3'd1, 1'b0);
    tick_check("sub_t2", 16'h4800, 3'd2, 1'b0);
    tick_check("sub_t3", 16'h1020, 3'd3, 1'b0);
    tick_check("sub_t4", 16'h02C1, 3'd4, 1'b0);
    tick_check("sub_wrap", 16'h4004, 3'd0, 1'b0);

    // JC not taken
    opcode = 4'h7; flag_c = 1'b0;
    tick_check("jc0_t1", 16'h1408, 3'd1, 1'b0);
    tick_check("jc0_t2", 16'h0000, 3'd2, 1'b0);
    tick_check("jc0_wrap", 16'h4004, 3'd0, 1'b0);

    // JC taken, with a flag toggle while stalled at T2
    flag_c = 1'b1;
    tick_check("jc1_t1", 16'h1408, 3'd1, 1'b0);
    tick_check("jc1_t2", 16'h0802, 3'd2, 1'b0);
    step_en = 1'b0; flag_c = 1'b0;
    #1 check("jc_stall_flag0", ctrl, 16'h0000);
    flag_c = 1'b1;
    #1 check("jc_stall_flag1", ctrl, 16'h0802);
    tick_check("jc_stall_hold", 16'h0802, 3'd2, 1'b0);
    step_en = 1'b1;
    tick_check("jc1_wrap", 16'h4004, 3'd0, 1'b0);

    // JZ taken (carry clear to show it uses the zero flag)
    opcode = 4'h8; flag_c = 1'b0; flag_z = 1'b1;
    tick_check("jz_t1", 16'h1408, 3'd1, 1'b0);
    tick_check("jz_t2", 16'h0802, 3'd2, 1'b0);
    tick_check("jz_wrap", 16'h4004, 3'd0, 1'b0);

    // Unused opcode behaves as NOP
    opcode = 4'hA;
    tick_check("nop_t1", 16'h1408, 3'd1, 1'b0);
    tick_check("nop_wrap", 16'h4004, 3'd0, 1'b0);

    // HLT
    opcode = 4'hF;
    tick_check("hlt_t1", 16'h1408, 3'd1, 1'b0);
    tick_check("hlt_t2", 16'h8000, 3'd2, 1'b0);
    tick_check("hlt_latched", 16'h8000, 3'd0, 1'b1);
    opcode = 4'h5;
    for (int i = 0; i < 10; i++) tick_check("hlt_hold", 16'h8000, 3'd0, 1'b1);
    rst = 1'b1;
    tick_check("hlt_reset", 16'h4004, 3'd0, 1'b0);
    rst = 1'b0;

    // ADD stalled at T3, then reset mid-instruction
    opcode = 4'h2;
    tick_check("add_t1", 16'h1408, 3'd1, 1'b0);
    tick_check("add_t2", 16'h4800, 3'd2, 1'b0);
    tick_check("add_t3", 16'h1020, 3'd3, 1'b0);
    step_en = 1'b0;
    for (int i = 0; i < 3; i++) tick_check("add_stall", 16'h1020, 3'd3, 1'b0);
    rst = 1'b1; step_en = 1'b1;
    tick_check("add_reset", 16'h4004, 3'd0, 1'b0);
    rst = 1'b0; step_en = 1'b0;
    tick_check("post_reset", 16'h4004, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
